uart_robot_frame_tx: RTL and testbench

//   Parametrised multi-byte UART frame transmitter for robot-arm command packets.

---
 rtl/uart_robot_frame_tx.sv | 167 ++++++++++++++++
 tb/tb_uart_robot_frame_tx.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_robot_frame_tx.sv
// uart_robot_frame_tx
// Sends one frame as back-to-back 8-bit UART characters: an optional header byte,
// 1..MAX_BYTES payload bytes, then an optional checksum (payload sum mod 256).
// Each character is a start bit, 8 data bits LSB first, an optional parity bit
// and 1 or 2 stop bits. Every bit lasts CLK_FREQ/UART_BPS clocks.
module uart_robot_frame_tx #(
  parameter int          CLK_FREQ    = 50_000_000,
  parameter int          UART_BPS    = 115200,
  parameter int          MAX_BYTES   = 16,
  parameter int          PARITY      = 0,
  parameter int          STOP_BITS   = 1,
  parameter int          HEADER_EN   = 1,
  parameter logic [7:0]  HEADER_BYTE = 8'hA5,
  parameter int          CSUM_EN     = 1,
  localparam int         LW          = $clog2(MAX_BYTES + 1)
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic [MAX_BYTES*8-1:0] s_data,
  input  logic [LW-1:0]          s_len,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic                   tx,
  output logic                   busy,
  output logic                   tx_done,
  output logic                   err_len
);

  localparam int              BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
  localparam int              CW           = (BAUD_CNT_MAX > 1) ? $clog2(BAUD_CNT_MAX) : 1;
  localparam logic [CW-1:0]   BAUD_LAST    = CW'(BAUD_CNT_MAX - 1);
  localparam logic [2:0]      STOP_LAST    = 3'(STOP_BITS - 1);
  localparam logic [LW-1:0]   LEN_MAX      = LW'(MAX_BYTES);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
  typedef enum logic [1:0] {PH_HDR, PH_PAY, PH_CSUM} phase_t;

  state_t                 r_state;
  state_t                 w_next;
  phase_t                 r_phase;
  logic [CW-1:0]          r_baud_cnt;
  logic [2:0]             r_bit_idx;
  logic [LW-1:0]          r_byte_idx;
  logic [LW-1:0]          r_len;
  logic [MAX_BYTES*8-1:0] r_data;
  logic [7:0]             r_csum;
  logic                   r_tx_done;
  logic                   r_err_len;

  logic                   w_ready;
  logic                   w_fire;
  logic                   w_len_ok;
  logic                   w_bit_end;
  logic                   w_byte_end;
  logic                   w_last_pay;
  logic                   w_last_byte;
  logic [MAX_BYTES*8-1:0] w_shifted;
  logic [7:0]             w_pay_byte;
  logic [7:0]             w_cur_byte;

  assign w_ready     = (r_state == S_IDLE);
  assign w_fire      = s_valid && w_ready;
  assign w_len_ok    = (s_len != '0) && (s_len <= LEN_MAX);
  assign w_bit_end   = (r_baud_cnt == BAUD_LAST);
  assign w_byte_end  = (r_state == S_STOP) && w_bit_end && (r_bit_idx == STOP_LAST);
  assign w_last_pay  = (r_byte_idx == r_len - LW'(1));
  assign w_last_byte = (r_phase == PH_CSUM) || ((r_phase == PH_PAY) && w_last_pay && (CSUM_EN == 0));
  assign w_shifted   = r_data >> {r_byte_idx, 3'b000};
  assign w_pay_byte  = w_shifted[7:0];

  // Select the character currently on the line from the frame phase.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    w_cur_byte = w_pay_byte;
    case (r_phase)
      PH_HDR:  w_cur_byte = HEADER_BYTE;
      PH_CSUM: w_cur_byte = r_csum;
      default: w_cur_byte = w_pay_byte;
    endcase
  end

  // State register.
  always_ff @(posedge sys_clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (sys_rst) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Next-state logic: walk the bits of a character, chain characters until the last one.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_fire && w_len_ok) w_next = S_START;
      S_START:  if (w_bit_end) w_next = S_DATA;
      S_DATA:   if (w_bit_end && (r_bit_idx == 3'd7)) w_next = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (w_bit_end) w_next = S_STOP;
      S_STOP:   if (w_byte_end) w_next = w_last_byte ? S_IDLE : S_START;
      default:  w_next = S_IDLE;
    endcase
  end

  // Datapath: baud/bit/byte counters, frame phase, running checksum and status pulses.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_byte_idx <= '0;
      r_len      <= '0;
      r_phase    <= PH_HDR;
      r_csum     <= '0;
      r_tx_done  <= 1'b0;
      r_err_len  <= 1'b0;
    end else begin
      r_tx_done <= w_byte_end && w_last_byte;
      r_err_len <= w_fire && !w_len_ok;
      if (w_fire) begin
        r_baud_cnt <= '0;
        r_bit_idx  <= '0;
        r_byte_idx <= '0;
        r_len      <= s_len;
        r_phase    <= (HEADER_EN != 0) ? PH_HDR : PH_PAY;
        r_csum     <= '0;
      end else if (r_state != S_IDLE) begin
        r_baud_cnt <= w_bit_end ? '0 : r_baud_cnt + CW'(1);
        if (w_bit_end) r_bit_idx <= (w_next != r_state) ? 3'd0 : r_bit_idx + 3'd1;
        if (w_byte_end) begin
          case (r_phase)
            PH_HDR: r_phase <= PH_PAY;
            PH_PAY: begin
              r_csum <= r_csum + w_pay_byte;
              if (w_last_pay) begin
                r_byte_idx <= '0;
                r_phase    <= PH_CSUM;
              end else begin
                r_byte_idx <= r_byte_idx + LW'(1);
              end
            end
            default: r_phase <= PH_HDR;
          endcase
        end
      end
    end
  end

  // Payload capture on every handshake.
  always_ff @(posedge sys_clk) begin
    // NOTE: the wide payload register is deliberately not reset; it is always loaded before it is read.
    if (w_fire) r_data <= s_data;
  end

  // Outputs decoded from the current state.
  always_comb begin
    tx      = 1'b1;
    s_ready = w_ready;
    busy    = !w_ready;
    case (r_state)
      S_START:  tx = 1'b0;
      S_DATA:   tx = w_cur_byte[r_bit_idx];
      S_PARITY: tx = (PARITY == 1) ? ~^w_cur_byte : ^w_cur_byte;
      default:  tx = 1'b1;
    endcase
  end

  assign tx_done = r_tx_done;
  assign err_len = r_err_len;

endmodule

// File: tb/tb_uart_robot_frame_tx.sv
// Testbench for uart_robot_frame_tx: three configurations at 10 clocks per bit,
// table-driven frame vectors plus hand-written reset, length-error and back-to-back sequences.
module tb_uart_robot_frame_tx;

  localparam int CLK_FREQ = 1_000_000;
  localparam int UART_BPS = 100_000;
  localparam int BIT      = 10;

  logic         clk = 1'b0;
  logic         sys_rst;
  logic [127:0] s_data;
  logic [4:0]   s_len;
  logic         s_valid;
  int           sel;

  always #5 clk = ~clk;

  logic v_a, v_b, v_c;
  logic rdy_a, tx_a, busy_a, done_a, err_a;
  logic rdy_b, tx_b, busy_b, done_b, err_b;
  logic rdy_c, tx_c, busy_c, done_c, err_c;
  logic m_rdy, m_tx, m_busy, m_done, m_err;

  assign v_a = s_valid && (sel == 0);
  assign v_b = s_valid && (sel == 1);
  assign v_c = s_valid && (sel == 2);

  // A: defaults (header, checksum, no parity, 1 stop bit), 16-byte payload.
  uart_robot_frame_tx #(.CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS)) u_a (
    .sys_clk(clk), .sys_rst(sys_rst), .s_data(s_data), .s_len(s_len), .s_valid(v_a),
    .s_ready(rdy_a), .tx(tx_a), .busy(busy_a), .tx_done(done_a), .err_len(err_a));

  // B: even parity, 2 stop bits, no header/checksum, 4-byte payload.
  uart_robot_frame_tx #(.CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS), .MAX_BYTES(4), .PARITY(2),
                        .STOP_BITS(2), .HEADER_EN(0), .CSUM_EN(0)) u_b (
    .sys_clk(clk), .sys_rst(sys_rst), .s_data(s_data[31:0]), .s_len(s_len[2:0]), .s_valid(v_b),
    .s_ready(rdy_b), .tx(tx_b), .busy(busy_b), .tx_done(done_b), .err_len(err_b));

  // C: odd parity, 1 stop bit, no header/checksum, 4-byte payload.
  uart_robot_frame_tx #(.CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS), .MAX_BYTES(4), .PARITY(1),
                        .STOP_BITS(1), .HEADER_EN(0), .CSUM_EN(0)) u_c (
    .sys_clk(clk), .sys_rst(sys_rst), .s_data(s_data[31:0]), .s_len(s_len[2:0]), .s_valid(v_c),
    .s_ready(rdy_c), .tx(tx_c), .busy(busy_c), .tx_done(done_c), .err_len(err_c));

  // Route the selected instance's outputs to the common checking logic.
  always_comb begin
    case (sel)
      1:       begin m_rdy = rdy_b; m_tx = tx_b; m_busy = busy_b; m_done = done_b; m_err = err_b; end
      2:       begin m_rdy = rdy_c; m_tx = tx_c; m_busy = busy_c; m_done = done_c; m_err = err_c; end
      default: begin m_rdy = rdy_a; m_tx = tx_a; m_busy = busy_a; m_done = done_a; m_err = err_a; end
    endcase
  end

  typedef struct packed {
    logic [1:0]       sel;
    logic [4:0]       len;
    logic [127:0]     data;
    int               nch;
    int               bpc;
    int               par;
    logic [17:0][7:0] bytes;
    logic [17:0]      parb;
  } vec_t;

  vec_t vt [9];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic rec_tx   [0:2047];
  logic rec_done [0:2047];
  logic rec_busy [0:2047];
  logic rec_rdy  [0:2047];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int s, input int len, input logic [127:0] data, input int nch,
                              input int bpc, input int par, input logic [143:0] bytes,
                              input logic [17:0] parb);
    vec_t v;
    v.sel   = 2'(s);
    v.len   = 5'(len);
    v.data  = data;
    v.nch   = nch;
    v.bpc   = bpc;
    v.par   = par;
    v.bytes = bytes;
    v.parb  = parb;
    return v;
  endfunction

  // Send one table vector, record the line for the whole frame, then decode and compare.
  task automatic run_vec(input int i);
    vec_t       v;
    int         frame, base, ndone;
    logic [7:0] got;
    logic       hold_bad, inv_bad, stop_ok, start_b;
    v     = vt[i];
    frame = v.nch * v.bpc * BIT;
    s_valid = 1'b0;
    sel     = int'(v.sel);
    @(negedge clk);
    check($sformatf("v%0d_ready_before", i), m_rdy, 1);
    s_data  = v.data;
    s_len   = v.len;
    s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    s_data  = ~v.data;
    s_len   = '0;
    for (int k = 1; k <= frame + 2; k++) begin
      rec_tx[k]   = m_tx;
      rec_done[k] = m_done;
      rec_busy[k] = m_busy;
      rec_rdy[k]  = m_rdy;
      @(negedge clk);
    end
    hold_bad = 1'b0;
    inv_bad  = 1'b0;
    ndone    = 0;
    for (int k = 1; k <= frame + 2; k++) begin
      if (rec_busy[k] === rec_rdy[k]) inv_bad = 1'b1;
      if (rec_done[k] === 1'b1) ndone++;
    end
    for (int c = 0; c < v.nch; c++) begin
      base = c * v.bpc * BIT;
      for (int b = 0; b < v.bpc; b++)
        for (int t = 1; t <= BIT; t++)
          if (rec_tx[base + b*BIT + t] !== rec_tx[base + b*BIT + 5]) hold_bad = 1'b1;
      start_b = rec_tx[base + 5];
      for (int j = 0; j < 8; j++) got[j] = rec_tx[base + (1 + j)*BIT + 5];
      check($sformatf("v%0d_byte%0d", i, c), got, v.bytes[c]);
      if (v.par != 0)
        check($sformatf("v%0d_parity%0d", i, c), rec_tx[base + 9*BIT + 5], v.parb[c]);
      stop_ok = 1'b1;
      for (int b = 9 + v.par; b < v.bpc; b++) stop_ok = stop_ok & rec_tx[base + b*BIT + 5];
      check($sformatf("v%0d_start_stop%0d", i, c), {start_b, stop_ok}, 2'b01);
    end
    check($sformatf("v%0d_bit_hold", i), hold_bad, 0);
    check($sformatf("v%0d_done_count", i), ndone, 1);
    check($sformatf("v%0d_done_at_end", i), rec_done[frame + 1], 1);
    check($sformatf("v%0d_idle_ready", i), {rec_tx[frame + 1], rec_rdy[frame + 1]}, 2'b11);
    check($sformatf("v%0d_busy_start", i), rec_busy[1], 1);
    check($sformatf("v%0d_busy_eq_not_ready", i), inv_bad, 0);
  endtask

  // Rejected length: one err_len pulse, line idle, ready held, no tx_done.
  task automatic run_bad_len(input int s, input int len);
    int n_err, n_done, n_low, n_notrdy;
    s_valid = 1'b0;
    sel     = s;
    @(negedge clk);
    s_len   = 5'(len);
    s_data  = 128'h55;
    s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    check($sformatf("badlen%0d_%0d_err_next", s, len), m_err, 1);
    n_err = 0; n_done = 0; n_low = 0; n_notrdy = 0;
    for (int k = 1; k <= 30; k++) begin
      if (m_err === 1'b1) n_err++;
      if (m_done !== 1'b0) n_done++;
      if (m_tx !== 1'b1) n_low++;
      if (m_rdy !== 1'b1 || m_busy !== 1'b0) n_notrdy++;
      @(negedge clk);
    end
    check($sformatf("badlen%0d_%0d_err_pulses", s, len), n_err, 1);
    check($sformatf("badlen%0d_%0d_quiet", s, len), {n_done[7:0], n_low[7:0], n_notrdy[7:0]}, 0);
  endtask

  initial begin
    int n_done, n_low;

    vt[0] = mk(0, 2,  128'h3412,     4,  10, 0, 144'h46_34_12_A5, 18'b0);
    vt[1] = mk(0, 2,  128'h02FF,     4,  10, 0, 144'h01_02_FF_A5, 18'b0);
    vt[2] = mk(0, 16, {16{8'hFF}},   18, 10, 0, {8'hF0, {16{8'hFF}}, 8'hA5}, 18'b0);
    vt[3] = mk(0, 1,  128'h5A,       3,  10, 0, 144'h5A_5A_A5, 18'b0);
    vt[4] = mk(1, 1,  128'h07,       1,  12, 1, 144'h07, 18'b1);
    vt[5] = mk(1, 1,  128'h03,       1,  12, 1, 144'h03, 18'b0);
    vt[6] = mk(2, 1,  128'h07,       1,  11, 1, 144'h07, 18'b0);
    vt[7] = mk(1, 3,  128'h0180FF,   3,  12, 1, 144'h01_80_FF, 18'b110);
    vt[8] = mk(2, 4,  128'h00010203, 4,  11, 1, 144'h00_01_02_03, 18'b1001);

    sys_rst = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    s_len   = '0;
    sel     = 0;
    repeat (3) @(negedge clk);
    check("reset_a_outputs", {tx_a, rdy_a, busy_a, done_a, err_a}, 5'b11000);
    check("reset_bc_outputs", {tx_b, rdy_b, busy_b, tx_c, rdy_c, busy_c}, 6'b110110);
    sys_rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) run_vec(i);

    run_bad_len(0, 0);
    run_bad_len(0, 17);
    run_bad_len(1, 5);

    // Back-to-back: s_valid held through tx_done; next start bit one cycle later.
    sel     = 0;
    s_data  = 128'h5A;
    s_len   = 5'd1;
    s_valid = 1'b1;
    @(negedge clk);
    for (int k = 1; k <= 603; k++) begin
      if (k == 300) check("b2b_last_stop_high", {m_tx, m_done}, 2'b10);
      if (k == 301) check("b2b_done_idle", {m_done, m_tx, m_rdy, m_busy}, 4'b1110);
      if (k == 302) begin
        check("b2b_second_start", {m_tx, m_busy}, 2'b01);
        s_valid = 1'b0;
      end
      if (k == 602) check("b2b_second_done", m_done, 1);
      if (k == 603) check("b2b_second_done_pulse", m_done, 0);
      @(negedge clk);
    end

    // Reset mid-payload, then a clean frame afterwards.
    sel     = 0;
    s_data  = 128'h44332211;
    s_len   = 5'd4;
    s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    repeat (149) @(negedge clk);
    check("midrst_before_busy", m_busy, 1);
    sys_rst = 1'b1;
    @(negedge clk);
    check("midrst_after_edge", {m_tx, m_busy, m_rdy, m_done}, 4'b1010);
    sys_rst = 1'b0;
    n_done = 0;
    n_low  = 0;
    for (int k = 0; k < 500; k++) begin
      if (m_done !== 1'b0) n_done++;
      if (m_tx !== 1'b1) n_low++;
      @(negedge clk);
    end
    check("midrst_no_done", n_done, 0);
    check("midrst_line_idle", n_low, 0);
    run_vec(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
